m_seq: RTL and testbench
========================

# m_seq

Multi-cycle sequencer for the RV32M unit. It accepts one M-extension operation at a time from the core and drives the M-unit ALU's control selects and its R/D/Z operand registers. For divides it iterates the ALU subtractor for 32 cycles, then applies sign fix-up and returns the 32-bit result over a valid/ready response channel.

## Interface
Parameters:
- none; mux widths and codes come from `m_definitions.svh` (`MUX_MULTA_*`, `MUX_MULTB_*`, `MUX_DIV_REM_*`).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  one clock; reset is asynchronous and active-low.
- req_valid  in  1  operation request.
- req_ready  out  1  high only in IDLE.
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1, req_rs2  in  32  operands (dividend/divisor for divides).
- resp_valid  out  1  result available.
- resp_ready  in  1  core accepts result.
- resp_result  out  32  result.
- mux_multA  out  `MUX_MULTA_LENGTH  ALU multiplier A select.
- mux_multB  out  `MUX_MULTB_LENGTH  ALU multiplier B select.
- mux_div_rem  out  `MUX_DIV_REM_LENGTH  ALU quotient/remainder select.
- R  out  32  remainder / multiplicand register.
- D  out  63  divisor register; multiplier operand in D[62:31].
- Z  out  32  quotient register.
- sub_result  in  32  ALU R−D; bit 31 is the sign.
- div_rem, div_rem_neg  in  32  ALU selected value and its negation.
- product  in  64  ALU product.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. A 5-bit iteration counter is used in DIV.
- IDLE: on `req_valid` with `req_ready`, latch funct3.
  - Multiplies: R=rs1, D={rs2,31'b0}, go MUL.
  - Divides: R=|rs1| for signed ops (raw for unsigned), D={|rs2|,31'b0}, Z=0, counter=0, go DIV.
  - Latch neg_q = signed op & (rs1[31]^rs2[31]) & (rs2≠0).
  - Latch neg_r = signed op & rs1[31].
- MUL: drive mux A/B per funct3.
  - MUL/MULHU: unsigned/unsigned.
  - MULH: signed/signed.
  - MULHSU: signed/unsigned.
  - Capture `product[31:0]` for MUL, otherwise `product[63:32]`, into resp_result; go DONE.
- DIV, per cycle:
  - If sub_result[31]==0: R←{1'b0,sub_result[30:0]}, Z←{Z[30:0],1}.
  - Else: R unchanged, Z←{Z[30:0],0}.
  - Always D←D>>1 and counter++. Leave DIV after counter==31 (32 iterations), go FIX.
- FIX: mux_div_rem = `MUX_DIV_REM_Z` for DIV/DIVU, `MUX_DIV_REM_R` for REM/REMU. resp_result ← div_rem_neg if (neg_q for DIV, neg_r for REM), else div_rem. Go DONE.
- DONE: resp_valid=1 and resp_result held stable until resp_ready, then go IDLE.
- Outside MUL, mux_multA/B are driven to `MUX_MULTA_ZERO`/`MUX_MULTB_ZERO` to keep the multiplier quiet.
- Divide by zero needs no special path except neg_q suppression. Results: quotient 0xFFFFFFFF, remainder = rs1.
- Overflow (0x80000000 / −1) falls out naturally: quotient 0x80000000, remainder 0.

## Timing
- Request handshake completes in cycle 0.
- MUL*: resp_valid first high in cycle 2.
- DIV*/REM*: 32 DIV cycles plus FIX; resp_valid first high in cycle 34.
- req_ready is low from the accept cycle until the cycle after response acceptance (no same-cycle response+request).
- resp_valid with resp_ready low: all outputs frozen.
- Reset values:
  - state IDLE, req_ready=1, resp_valid=0, resp_result=0.
  - R=0, D=0, Z=0, counter=0.
  - mux_multA=`MUX_MULTA_ZERO`, mux_multB=`MUX_MULTB_ZERO`, mux_div_rem=`MUX_DIV_REM_Z`.
- resetn asserted mid-operation: immediate return to the reset values; the in-flight operation is dropped with no response.

## Configuration
- `M_SEQ_DIV_ZERO_FAST_EN` defined: a divide with rs2==0 loads Z=0xFFFFFFFF and R=|rs1| (raw for unsigned), then goes straight to FIX. resp_valid is first high in cycle 2.
- Undefined: divide by zero runs the full 32 iterations (cycle 34). Results are identical either way.

## Test plan
- MUL 7×6 -> resp_result 0x0000002A, resp_valid first high in cycle 2. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD at cycle 34; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB.
  - Latency 34 without `M_SEQ_DIV_ZERO_FAST_EN`, 2 with it.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold resp_ready low 5 cycles after resp_valid -> resp_result stable, req_ready low. New req_valid is ignored until the cycle after acceptance.
- Assert resetn low at DIV iteration 10 -> all outputs at reset values asynchronously. A subsequent MUL 3×3 returns 9 in cycle 2.

Source files
------------

// File: rtl/m_seq.sv
// Multi-cycle sequencer for the RV32M unit: steers the external M-unit ALU for
// multiplies and iterates a restoring divide. Optional macro: M_SEQ_DIV_ZERO_FAST_EN.
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH    2
`define MUX_MULTA_ZERO      2'd0
`define MUX_MULTA_UNSIGNED  2'd1
`define MUX_MULTA_SIGNED    2'd2
`define MUX_MULTB_LENGTH    2
`define MUX_MULTB_ZERO      2'd0
`define MUX_MULTB_UNSIGNED  2'd1
`define MUX_MULTB_SIGNED    2'd2
`define MUX_DIV_REM_LENGTH  1
`define MUX_DIV_REM_Z       1'b0
`define MUX_DIV_REM_R       1'b1
`endif

module m_seq (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_funct3,
  input  logic [31:0]                     req_rs1,
  input  logic [31:0]                     req_rs2,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [31:0]                     resp_result,
  output logic [`MUX_MULTA_LENGTH-1:0]    mux_multA,
  output logic [`MUX_MULTB_LENGTH-1:0]    mux_multB,
  output logic [`MUX_DIV_REM_LENGTH-1:0]  mux_div_rem,
  output logic [31:0]                     R,
  output logic [62:0]                     D,
  output logic [31:0]                     Z,
  input  logic [31:0]                     sub_result,
  input  logic [31:0]                     div_rem,
  input  logic [31:0]                     div_rem_neg,
  input  logic [63:0]                     product
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [2:0]                      funct3_q, funct3_d;
  logic                            neg_quo_q, neg_quo_d;
  logic                            neg_rem_q, neg_rem_d;
  logic [4:0]                      cnt_q, cnt_d;
  logic [31:0]                     r_q, r_d;
  logic [62:0]                     d_q, d_d;
  logic [31:0]                     z_q, z_d;
  logic [31:0]                     result_q, result_d;
  logic                            req_ready_q, req_ready_d;
  logic                            resp_valid_q, resp_valid_d;
  logic [`MUX_MULTA_LENGTH-1:0]    mux_a_q, mux_a_d;
  logic [`MUX_MULTB_LENGTH-1:0]    mux_b_q, mux_b_d;
  logic [`MUX_DIV_REM_LENGTH-1:0]  mux_dr_q, mux_dr_d;
  logic                            signed_op_s;

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    abs32 = (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign mux_multA   = mux_a_q;
  assign mux_multB   = mux_b_q;
  assign mux_div_rem = mux_dr_q;
  assign R           = r_q;
  assign D           = d_q;
  assign Z           = z_q;
  // DIV and REM are the signed divides (funct3[0] clear).
  assign signed_op_s = ~req_funct3[0];

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    d_d          = d_q;
    z_d          = z_q;
    result_d     = result_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    mux_a_d      = mux_a_q;
    mux_b_d      = mux_b_q;
    mux_dr_d     = mux_dr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          funct3_d    = req_funct3;
          req_ready_d = 1'b0;
          if (!req_funct3[2]) begin
            r_d       = req_rs1;
            d_d       = {req_rs2, 31'd0};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_MUL;
            case (req_funct3[1:0])
              2'b01: begin
                mux_a_d = `MUX_MULTA_SIGNED;
                mux_b_d = `MUX_MULTB_SIGNED;
              end
              2'b10: begin
                mux_a_d = `MUX_MULTA_SIGNED;
                mux_b_d = `MUX_MULTB_UNSIGNED;
              end
              default: begin
                mux_a_d = `MUX_MULTA_UNSIGNED;
                mux_b_d = `MUX_MULTB_UNSIGNED;
              end
            endcase
          end else begin
            r_d       = abs32(req_rs1, signed_op_s);
            d_d       = {abs32(req_rs2, signed_op_s), 31'd0};
            z_d       = 32'd0;
            cnt_d     = 5'd0;
            neg_quo_d = signed_op_s & (req_rs1[31] ^ req_rs2[31]) & (req_rs2 != 32'd0);
            neg_rem_d = signed_op_s & req_rs1[31];
            mux_dr_d  = req_funct3[1] ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z;
            state_d   = S_DIV;
`ifdef M_SEQ_DIV_ZERO_FAST_EN
            if (req_rs2 == 32'd0) begin
              z_d     = 32'hFFFF_FFFF;
              state_d = S_FIX;
            end else begin
              state_d = S_DIV;
            end
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        result_d     = (funct3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
        mux_a_d      = `MUX_MULTA_ZERO;
        mux_b_d      = `MUX_MULTB_ZERO;
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DIV: begin
        if (!sub_result[31]) begin
          r_d = {1'b0, sub_result[30:0]};
          z_d = {z_q[30:0], 1'b1};
        end else begin
          z_d = {z_q[30:0], 1'b0};
        end
        d_d   = {1'b0, d_q[62:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_DIV;
        end
      end
      S_FIX: begin
        result_d     = (funct3_q[1] ? neg_rem_q : neg_quo_q) ? div_rem_neg : div_rem;
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mux_a_d      = `MUX_MULTA_ZERO;
        mux_b_d      = `MUX_MULTB_ZERO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'd0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      cnt_q        <= 5'd0;
      r_q          <= 32'd0;
      d_q          <= 63'd0;
      z_q          <= 32'd0;
      result_q     <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mux_a_q      <= `MUX_MULTA_ZERO;
      mux_b_q      <= `MUX_MULTB_ZERO;
      mux_dr_q     <= `MUX_DIV_REM_Z;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      d_q          <= d_d;
      z_q          <= z_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mux_a_q      <= mux_a_d;
      mux_b_q      <= mux_b_d;
      mux_dr_q     <= mux_dr_d;
    end
  end

endmodule

// File: tb/tb_m_seq.sv
// Directed testbench for m_seq with a behavioural model of the M-unit ALU.
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH    2
`define MUX_MULTA_ZERO      2'd0
`define MUX_MULTA_UNSIGNED  2'd1
`define MUX_MULTA_SIGNED    2'd2
`define MUX_MULTB_LENGTH    2
`define MUX_MULTB_ZERO      2'd0
`define MUX_MULTB_UNSIGNED  2'd1
`define MUX_MULTB_SIGNED    2'd2
`define MUX_DIV_REM_LENGTH  1
`define MUX_DIV_REM_Z       1'b0
`define MUX_DIV_REM_R       1'b1
`endif

module tb_m_seq;
  logic clk = 1'b0;
  logic resetn, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0] req_funct3;
  logic [31:0] req_rs1, req_rs2, resp_result, R, Z, sub_result, div_rem, div_rem_neg;
  logic [62:0] D;
  logic [63:0] product, diff, a64, b64;
  logic [`MUX_MULTA_LENGTH-1:0] mux_multA;
  logic [`MUX_MULTB_LENGTH-1:0] mux_multB;
  logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
  int checks = 0;
  int errors = 0;
`ifdef M_SEQ_DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif

  always #5 clk = ~clk;

  m_seq dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_div_rem(mux_div_rem),
    .R(R), .D(D), .Z(Z), .sub_result(sub_result), .div_rem(div_rem),
    .div_rem_neg(div_rem_neg), .product(product)
  );

  // ALU model: borrow of the full-width R-D is reported as the sign bit.
  always_comb begin
    diff        = {32'd0, R} - {1'b0, D};
    sub_result  = {diff[63], diff[30:0]};
    div_rem     = (mux_div_rem == `MUX_DIV_REM_R) ? R : Z;
    div_rem_neg = 32'd0 - div_rem;
    a64 = (mux_multA == `MUX_MULTA_SIGNED) ? {{32{R[31]}}, R} : {32'd0, R};
    b64 = (mux_multB == `MUX_MULTB_SIGNED) ? {{32{D[62]}}, D[62:31]} : {32'd0, D[62:31]};
    product = (mux_multA == `MUX_MULTA_ZERO) ? 64'd0 : a64 * b64;
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output logic rdy);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      lat++;
    end
    res = resp_result;
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", resp_result); end
    checks++; if ({R, Z} !== 64'd0 || D !== 63'd0) begin errors++; $display("FAIL reset_rdz got R=%h D=%h Z=%h want 0", R, D, Z); end
    checks++; if (mux_multA !== `MUX_MULTA_ZERO || mux_multB !== `MUX_MULTB_ZERO || mux_div_rem !== `MUX_DIV_REM_Z) begin
      errors++; $display("FAIL reset_mux got A=%0d B=%0d DR=%0d want 0 0 0", mux_multA, mux_multB, mux_div_rem); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] a  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [4] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] ex [4] = '{32'h0000_002A, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] res; int lat; logic rdy;
    for (int i = 0; i < 4; i++) begin
      issue(f3[i], a[i], b[i], res, lat, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL mul%0d_req_ready got %b want 1", i, rdy); end
      checks++; if (lat != 2) begin errors++; $display("FAIL mul%0d_latency got %0d want 2", i, lat); end
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL mul%0d_result got %h want %h", i, res, ex[i]); end
      checks++; if (mux_multA !== `MUX_MULTA_ZERO) begin errors++; $display("FAIL mul%0d_muxA_quiet got %0d want 0", i, mux_multA); end
      accept();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [11] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b100, 3'b110,
                             3'b100, 3'b110, 3'b111, 3'b100};
    logic [31:0] a  [11] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'hFFFF_FFFB,
                             32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd42};
    logic [31:0] b  [11] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFA};
    logic [31:0] ex [11] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFB, 32'h8000_0000, 32'd0, 32'd5, 32'hFFFF_FFF9};
    int          el [11] = '{34, 34, 34, 34, DZ_LAT, DZ_LAT, DZ_LAT, 34, 34, DZ_LAT, 34};
    logic [31:0] res; int lat; logic rdy;
    for (int i = 0; i < 11; i++) begin
      issue(f3[i], a[i], b[i], res, lat, rdy);
      checks++; if (lat != el[i]) begin errors++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, el[i]); end
      checks++; if (res !== ex[i]) begin errors++; $display("FAIL div%0d_result got %h want %h", i, res, ex[i]); end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; logic rdy;
    issue(3'b101, 32'd100, 32'd7, res, lat, rdy);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL bp_result got %h want 0000000e", res); end
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd2; req_rs2 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (resp_result !== 32'd14 || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got result=%h valid=%b ready=%b want 0000000e 1 0", i, resp_result, resp_valid, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle_after_accept got ready=%b valid=%b want 1 0", req_ready, resp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(negedge clk);
      if (resp_valid) break;
      @(posedge clk);
      lat++;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", lat); end
    checks++; if (resp_result !== 32'd4) begin errors++; $display("FAIL b2b_result got %h want 00000004", resp_result); end
    accept();
  endtask

  task automatic test_mid_reset();
    logic [31:0] res; int lat; logic rdy;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd1000; req_rs2 = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || Z === 32'd0 && R === 32'd0) begin
      errors++; $display("FAIL mid_busy got ready=%b R=%h want 0 and busy", req_ready, R); end
    resetn = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== 32'd0) begin
      errors++; $display("FAIL mid_reset_ctrl got ready=%b valid=%b result=%h want 1 0 0", req_ready, resp_valid, resp_result); end
    checks++; if ({R, Z} !== 64'd0 || D !== 63'd0) begin
      errors++; $display("FAIL mid_reset_rdz got R=%h D=%h Z=%h want 0", R, D, Z); end
    checks++; if (mux_multA !== `MUX_MULTA_ZERO || mux_multB !== `MUX_MULTB_ZERO || mux_div_rem !== `MUX_DIV_REM_Z) begin
      errors++; $display("FAIL mid_reset_mux got A=%0d B=%0d DR=%0d want 0 0 0", mux_multA, mux_multB, mux_div_rem); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dropped got valid=%b want 0", resp_valid); end
    issue(3'b000, 32'd3, 32'd3, res, lat, rdy);
    checks++; if (lat != 2) begin errors++; $display("FAIL post_reset_latency got %0d want 2", lat); end
    checks++; if (res !== 32'd9) begin errors++; $display("FAIL post_reset_result got %h want 00000009", res); end
    accept();
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
